// File: rtl/memoria_dados_if.sv
// Bus between the ALU/control side of the MIPS datapath and the data memory stage.
interface memoria_dados_if;
    logic [31:0] endereco;
    logic [31:0] dado_escrita;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  tamanho;
    logic        sem_sinal;
    logic [31:0] dado_leitura;
    logic        desalinhado;

    modport master (
        output endereco, dado_escrita, MemRead, MemWrite, tamanho, sem_sinal,
        input  dado_leitura, desalinhado
    );

    modport slave (
        input  endereco, dado_escrita, MemRead, MemWrite, tamanho, sem_sinal,
        output dado_leitura, desalinhado
    );
endinterface

// File: rtl/memoria_dados.sv
// Big-endian data memory for the single-cycle MIPS datapath: combinational loads, clocked byte-lane stores.
// Optional MEMORIA_DADOS_EXCECAO_EN adds a sticky misalignment flag and first-faulting-address capture.
module memoria_dados #(
    parameter int PALAVRAS = 256,
    parameter int IDX_W    = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    memoria_dados_if.slave   bus
`ifdef MEMORIA_DADOS_EXCECAO_EN
    ,
    output logic             erro_sticky,
    output logic [31:0]      endereco_erro
`endif
);

    logic [31:0]      memoria_q [PALAVRAS];
    logic [IDX_W-1:0] idx;
    logic [1:0]       offset;
    logic             acesso;
    logic             desal;
    logic [31:0]      palavra;
    logic [7:0]       byteSel;
    logic [15:0]      meiaSel;
    logic [3:0]       laneEn;
    logic [31:0]      dadoAlinhado;
    logic             escreve;
    logic             unusedBits;

    assign idx        = bus.endereco[IDX_W+1:2];
    assign offset     = bus.endereco[1:0];
    assign unusedBits = ^bus.endereco[31:IDX_W+2];
    assign acesso     = bus.MemRead | bus.MemWrite;

    always_comb begin
        desal = 1'b0;
        if (acesso) begin
            case (bus.tamanho)
                2'b01:   desal = offset[0];
                2'b10:   desal = (offset != 2'b00);
                2'b11:   desal = 1'b1;
                default: desal = 1'b0;
            endcase
        end
    end

    assign bus.desalinhado = desal;
    assign palavra         = memoria_q[idx];

    // Byte b lives in bits [31-8b : 24-8b], so offset 0 is the most significant lane.
    always_comb begin
        byteSel = 8'h00;
        case (offset)
            2'd0:    byteSel = palavra[31:24];
            2'd1:    byteSel = palavra[23:16];
            2'd2:    byteSel = palavra[15:8];
            default: byteSel = palavra[7:0];
        endcase
        meiaSel = offset[1] ? palavra[15:0] : palavra[31:16];
    end

    always_comb begin
        bus.dado_leitura = 32'h0;
        if (reset_n && bus.MemRead && !desal) begin
            case (bus.tamanho)
                2'b00:   bus.dado_leitura = {{24{byteSel[7] & ~bus.sem_sinal}}, byteSel};
                2'b01:   bus.dado_leitura = {{16{meiaSel[15] & ~bus.sem_sinal}}, meiaSel};
                default: bus.dado_leitura = palavra;
            endcase
        end
    end

    always_comb begin
        laneEn       = 4'b0000;
        dadoAlinhado = bus.dado_escrita;
        case (bus.tamanho)
            2'b00: begin
                laneEn       = 4'b1000 >> offset;
                dadoAlinhado = {4{bus.dado_escrita[7:0]}};
            end
            2'b01: begin
                laneEn       = offset[1] ? 4'b0011 : 4'b1100;
                dadoAlinhado = {2{bus.dado_escrita[15:0]}};
            end
            2'b10:   laneEn = 4'b1111;
            default: laneEn = 4'b0000;
        endcase
    end

    assign escreve = bus.MemWrite & ~desal;

    // Only the enabled lanes are written, so untouched bytes keep their value without a read-modify-write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PALAVRAS; i++) begin
                memoria_q[i] <= 32'h0;
            end
        end else if (escreve) begin
            for (int l = 0; l < 4; l++) begin
                if (laneEn[l]) begin
                    memoria_q[idx][8*l +: 8] <= dadoAlinhado[8*l +: 8];
                end
            end
        end
    end

`ifdef MEMORIA_DADOS_EXCECAO_EN
    logic        erroSticky_q;
    logic [31:0] enderecoErro_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            erroSticky_q   <= 1'b0;
            enderecoErro_q <= 32'h0;
        end else if (desal) begin
            erroSticky_q <= 1'b1;
            if (!erroSticky_q) begin
                enderecoErro_q <= bus.endereco;
            end
        end
    end

    assign erro_sticky   = erroSticky_q;
    assign endereco_erro = enderecoErro_q;
`endif

endmodule

// File: tb/tb_memoria_dados.sv
// Directed self-checking bench for memoria_dados; exception checks compile in with MEMORIA_DADOS_EXCECAO_EN.
module tb_memoria_dados;

    logic clock = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    memoria_dados_if bus ();

`ifdef MEMORIA_DADOS_EXCECAO_EN
    logic        erro_sticky;
    logic [31:0] endereco_erro;
`endif

    memoria_dados #(.PALAVRAS(256), .IDX_W(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus)
`ifdef MEMORIA_DADOS_EXCECAO_EN
        ,
        .erro_sticky  (erro_sticky),
        .endereco_erro(endereco_erro)
`endif
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observado, input logic [31:0] esperado);
        checks++;
        if (observado !== esperado) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observado, esperado);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] dado, input logic rd,
                                 input logic wr, input logic [1:0] tam, input logic sem);
        bus.endereco     = addr;
        bus.dado_escrita = dado;
        bus.MemRead      = rd;
        bus.MemWrite     = wr;
        bus.tamanho      = tam;
        bus.sem_sinal    = sem;
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] dado, input logic [1:0] tam);
        applyStimulus(addr, dado, 1'b0, 1'b1, tam, 1'b0);
        @(posedge clock);
        #1;
        applyStimulus(addr, dado, 1'b0, 1'b0, tam, 1'b0);
    endtask

    task automatic load(input logic [31:0] addr, input logic [1:0] tam, input logic sem);
        applyStimulus(addr, 32'h0, 1'b1, 1'b0, tam, sem);
    endtask

    initial begin
        reset_n = 1'b0;
        load(32'h10, 2'b10, 1'b0);
        checkOutput("reset_lw", bus.dado_leitura, 32'h0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        load(32'h10, 2'b10, 1'b0);
        checkOutput("post_reset_lw", bus.dado_leitura, 32'h0);
        checkOutput("post_reset_desal", {31'b0, bus.desalinhado}, 32'h0);

        store(32'h10, 32'hDEADBEEF, 2'b10);
        load(32'h10, 2'b10, 1'b0);
        checkOutput("lw_deadbeef", bus.dado_leitura, 32'hDEADBEEF);
        reset_n = 1'b0;
        #1;
        checkOutput("reset_mid_cycle", bus.dado_leitura, 32'h0);
        #1 reset_n = 1'b1;
        load(32'h10, 2'b10, 1'b0);
        checkOutput("array_cleared", bus.dado_leitura, 32'h0);

        // Store pending across an edge while reset is held must be lost.
        applyStimulus(32'h14, 32'h12345678, 1'b0, 1'b1, 2'b10, 1'b0);
        reset_n = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b1;
        applyStimulus(32'h14, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);
        load(32'h14, 2'b10, 1'b0);
        checkOutput("store_lost_in_reset", bus.dado_leitura, 32'h0);

        store(32'h20, 32'h11223344, 2'b10);
        load(32'h20, 2'b00, 1'b0);
        checkOutput("lb_20", bus.dado_leitura, 32'h00000011);
        load(32'h21, 2'b00, 1'b0);
        checkOutput("lb_21", bus.dado_leitura, 32'h00000022);
        load(32'h23, 2'b00, 1'b0);
        checkOutput("lb_23", bus.dado_leitura, 32'h00000044);
        load(32'h22, 2'b01, 1'b0);
        checkOutput("lh_22", bus.dado_leitura, 32'h00003344);

        store(32'h40, 32'h80FF7F01, 2'b10);
        load(32'h40, 2'b00, 1'b0);
        checkOutput("lb_40", bus.dado_leitura, 32'hFFFFFF80);
        load(32'h40, 2'b00, 1'b1);
        checkOutput("lbu_40", bus.dado_leitura, 32'h00000080);
        load(32'h40, 2'b01, 1'b0);
        checkOutput("lh_40", bus.dado_leitura, 32'hFFFF80FF);
        load(32'h40, 2'b01, 1'b1);
        checkOutput("lhu_40", bus.dado_leitura, 32'h000080FF);
        load(32'h42, 2'b00, 1'b0);
        checkOutput("lb_42", bus.dado_leitura, 32'h0000007F);
        load(32'h43, 2'b00, 1'b0);
        checkOutput("lb_43", bus.dado_leitura, 32'h00000001);

        store(32'h50, 32'hAAAAAAAA, 2'b10);
        store(32'h51, 32'h000000CC, 2'b00);
        store(32'h52, 32'h00001234, 2'b01);
        load(32'h50, 2'b10, 1'b0);
        checkOutput("lane_merge", bus.dado_leitura, 32'hAACC1234);

        store(32'h60, 32'hCAFEF00D, 2'b10);
        load(32'h61, 2'b10, 1'b0);
        checkOutput("lw_61_desal", {31'b0, bus.desalinhado}, 32'h1);
        checkOutput("lw_61_data", bus.dado_leitura, 32'h0);
        @(posedge clock);
        #1;
`ifdef MEMORIA_DADOS_EXCECAO_EN
        checkOutput("erro_sticky", {31'b0, erro_sticky}, 32'h1);
        checkOutput("endereco_erro", endereco_erro, 32'h00000061);
`endif
        applyStimulus(32'h63, 32'h0000BEEF, 1'b0, 1'b1, 2'b01, 1'b0);
        checkOutput("sh_63_desal", {31'b0, bus.desalinhado}, 32'h1);
        @(posedge clock);
        #1;
        load(32'h60, 2'b10, 1'b0);
        checkOutput("word_60_kept", bus.dado_leitura, 32'hCAFEF00D);
`ifdef MEMORIA_DADOS_EXCECAO_EN
        checkOutput("endereco_erro_held", endereco_erro, 32'h00000061);
`endif
        load(32'h60, 2'b11, 1'b0);
        checkOutput("reserved_desal", {31'b0, bus.desalinhado}, 32'h1);
        checkOutput("reserved_data", bus.dado_leitura, 32'h0);
        applyStimulus(32'h61, 32'h0, 1'b0, 1'b0, 2'b11, 1'b0);
        checkOutput("idle_no_desal", {31'b0, bus.desalinhado}, 32'h0);
        load(32'h40, 2'b10, 1'b0);
        checkOutput("word_40_intact", bus.dado_leitura, 32'h80FF7F01);

        store(32'h00000404, 32'h5A5A5A5A, 2'b10);
        load(32'h00000004, 2'b10, 1'b0);
        checkOutput("wrap_lw", bus.dado_leitura, 32'h5A5A5A5A);

        store(32'h8, 32'h77777777, 2'b10);
        applyStimulus(32'h8, 32'h00000001, 1'b1, 1'b1, 2'b10, 1'b0);
        checkOutput("same_cycle_old", bus.dado_leitura, 32'h77777777);
        @(posedge clock);
        #1;
        checkOutput("same_cycle_new", bus.dado_leitura, 32'h00000001);
        applyStimulus(32'h8, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);
        load(32'h8, 2'b10, 1'b0);
        checkOutput("no_read_zero", bus.dado_leitura, 32'h00000001);
        applyStimulus(32'h8, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);
        checkOutput("read_disabled", bus.dado_leitura, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
